fetch_next_pc_gen: RTL and testbench
====================================

# fetch_next_pc_gen

Fetch-stage next-PC generator sitting directly upstream of the JALR target predictor. Holds the fetch-group PC register, drives the five per-slot lookup PCs, and consumes the predictor's single JALR prediction together with the branch predictor's taken/target result and backend redirects. It selects the next fetch PC, truncates the current group at the first taken control-flow slot, and stalls fetch on an unpredicted JALR.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC width
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- current_pc_0..current_pc_4  out  ADDR_WIDTH each  slot PCs = pc_q + 4*i, to predictors and I-cache
- is_jalr_i_0..is_jalr_i_4  in  1 each  predecode: slot i holds a JALR
- jalr_prediction_valid_i  in  1  predictor hit for earliest JALR
- jalr_prediction_target_i  in  ADDR_WIDTH  predicted JALR target
- branch_taken_i  in  1  branch predictor: taken branch in group
- branch_slot_i  in  3  slot of that taken branch (0..4)
- branch_target_i  in  ADDR_WIDTH  its target
- redirect_valid_i  in  1  backend misprediction redirect
- redirect_pc_i  in  ADDR_WIDTH  redirect target
- fetch_ready_i  in  1  instruction buffer accepts a group this cycle
- fetch_valid_o  out  1  current group is valid
- group_mask_o  out  5  valid slots of the current group
- jalr_stall_o  out  1  fetch held waiting for JALR resolution
- stall_count_o  out  16  cycles spent in WAIT_JALR (only with macro)

## Operation
- States: FETCH, WAIT_JALR. Reset -> FETCH, pc_q = RESET_PC.
- jalr_slot = lowest i with is_jalr_i_i. cf_slot = min(jalr_slot, branch_slot_i if branch_taken_i); tie impossible (one slot one instruction); branch wins if equal.
- FETCH, no redirect:
  - fetch_valid_o = 1; group_mask_o = bits 0..cf_slot set, or 5'b11111 if no control flow.
  - Handshake: group consumed only when fetch_valid_o && fetch_ready_i. If !fetch_ready_i: pc_q held, all outputs stable.
  - On consume: next = branch_target_i if branch is cf_slot; jalr_prediction_target_i if JALR is cf_slot and jalr_prediction_valid_i; pc_q + 20 if no control flow.
  - JALR at cf_slot, prediction invalid: with macro, group consumed with mask through jalr_slot, pc_q held, -> WAIT_JALR; without macro, next = pc_q + 4*(jalr_slot+1), stays FETCH.
- WAIT_JALR: fetch_valid_o = 0, group_mask_o = 0, jalr_stall_o = 1; leaves only on redirect.
- redirect_valid_i (any state, regardless of fetch_ready_i): pc_q <= {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00}, -> FETCH; current group dropped (fetch_valid_o forced 0 this cycle).
- Arithmetic: all PC adds modulo 2^ADDR_WIDTH; slot PCs wrap past 32'hFFFF_FFFC. Target bits [1:0] forced to 0.
- stall_count_o: increments each cycle in WAIT_JALR, saturates at 16'hFFFF, never cleared except by reset.

## Timing
- Reset values: pc_q = RESET_PC, current_pc_i = RESET_PC + 4i, fetch_valid_o = 0 while reset high, group_mask_o = 0, jalr_stall_o = 0, stall_count_o = 0.
- First cycle after reset release: fetch_valid_o = 1 at RESET_PC.
- current_pc_* combinational from pc_q; prediction inputs are same-cycle combinational returns; next PC visible one cycle after consume or redirect.
- Redirect in WAIT_JALR: FETCH next cycle, stall_count_o does not increment that cycle's successor.
- Reset mid-WAIT_JALR: immediate return to FETCH/RESET_PC, counter cleared.

## Configuration
- JALR_STALL_ON_MISS_EN defined: unpredicted JALR enters WAIT_JALR; stall_count_o present and counting.
- Undefined: WAIT_JALR unreachable, fall-through after JALR, jalr_stall_o and stall_count_o tied to 0.

## Structure
- fetch_pkg: FETCH_WIDTH = 5, SLOT_IDX_W = 3, fetch_state_e {FETCH, WAIT_JALR}, PC_STEP = 4.
- Sub-module fetch_slot_prio_enc: 5-bit request -> found flag + 3-bit lowest index; used for jalr_slot.

## Test plan
- Reset release, fetch_ready_i=1, no control flow -> PCs 0x0, 0x14, 0x28 on consecutive cycles, mask 5'b11111.
- pc_q=0x100, is_jalr_i_2=1, prediction valid target 0x400 -> mask 5'b00111, next pc_q=0x400.
- pc_q=0x100, jalr slot 3 and taken branch slot 1 target 0x200 -> mask 5'b00011, next 0x200.
- Unpredicted JALR slot 0 with macro -> WAIT_JALR, fetch_valid_o=0, stall_count_o=3 after 3 cycles; redirect 0x803 -> pc_q=0x800, FETCH. Without macro -> next 0x104.
- fetch_ready_i=0 for 4 cycles at pc 0x40 -> outputs stable; redirect 0x1000 during stall -> pc_q=0x1000 next cycle.
- pc_q=0xFFFF_FFF0 -> current_pc_4 = 0x0000_0000, next group 0x0000_0004.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants for the next-PC generator.
package fetch_pkg;

    localparam int unsigned FETCH_WIDTH = 5;
    localparam int unsigned SLOT_IDX_W  = 3;
    localparam int unsigned PC_STEP     = 4;

    typedef enum logic [0:0] {
        FETCH,
        WAIT_JALR
    } fetch_state_e;

    // Slots 0..slot inclusive are valid in a group truncated at slot.
    function automatic logic [FETCH_WIDTH-1:0] slot_mask(input logic [SLOT_IDX_W-1:0] slot);
        logic [FETCH_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (i <= int'(slot)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/fetch_slot_prio_enc.sv
// Lowest-index priority encoder over the fetch-group slots.
module fetch_slot_prio_enc
    import fetch_pkg::*;
(
    input  logic [FETCH_WIDTH-1:0] req_i,
    output logic                   found_o,
    output logic [SLOT_IDX_W-1:0]  idx_o
);

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        // Descending scan so the lowest set request is the last one written.
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = SLOT_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/fetch_next_pc_gen.sv
// Fetch-group PC register and next-PC selection; JALR_STALL_ON_MISS_EN enables
// the WAIT_JALR stall on an unpredicted JALR and the stall cycle counter.
module fetch_next_pc_gen
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] current_pc_0,
    output logic [ADDR_WIDTH-1:0] current_pc_1,
    output logic [ADDR_WIDTH-1:0] current_pc_2,
    output logic [ADDR_WIDTH-1:0] current_pc_3,
    output logic [ADDR_WIDTH-1:0] current_pc_4,
    input  logic                  is_jalr_i_0,
    input  logic                  is_jalr_i_1,
    input  logic                  is_jalr_i_2,
    input  logic                  is_jalr_i_3,
    input  logic                  is_jalr_i_4,
    input  logic                  jalr_prediction_valid_i,
    input  logic [ADDR_WIDTH-1:0] jalr_prediction_target_i,
    input  logic                  branch_taken_i,
    input  logic [2:0]            branch_slot_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    input  logic                  fetch_ready_i,
    output logic                  fetch_valid_o,
    output logic [4:0]            group_mask_o,
    output logic                  jalr_stall_o,
    output logic [15:0]           stall_count_o
);

    localparam logic [ADDR_WIDTH-1:0] AlignMask = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] GroupStep = ADDR_WIDTH'(PC_STEP * FETCH_WIDTH);

    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    fetch_state_e           state_q, state_d;
    logic [FETCH_WIDTH-1:0] jalr_req;
    logic                   jalr_found;
    logic [SLOT_IDX_W-1:0]  jalr_slot;
    logic                   cf_is_branch, cf_is_jalr;
    logic [SLOT_IDX_W-1:0]  cf_slot;

    assign current_pc_0 = pc_q;
    assign current_pc_1 = pc_q + ADDR_WIDTH'(1 * PC_STEP);
    assign current_pc_2 = pc_q + ADDR_WIDTH'(2 * PC_STEP);
    assign current_pc_3 = pc_q + ADDR_WIDTH'(3 * PC_STEP);
    assign current_pc_4 = pc_q + ADDR_WIDTH'(4 * PC_STEP);

    assign jalr_req = {is_jalr_i_4, is_jalr_i_3, is_jalr_i_2, is_jalr_i_1, is_jalr_i_0};

    fetch_slot_prio_enc u_jalr_enc (
        .req_i   (jalr_req),
        .found_o (jalr_found),
        .idx_o   (jalr_slot)
    );

    // A slot holds one instruction, so an equal slot can only mean the branch.
    assign cf_is_branch = branch_taken_i && (!jalr_found || (branch_slot_i <= jalr_slot));
    assign cf_is_jalr   = jalr_found && !cf_is_branch;
    assign cf_slot      = cf_is_branch ? branch_slot_i : jalr_slot;

    always_comb begin
        pc_d          = pc_q;
        state_d       = state_q;
        fetch_valid_o = 1'b0;
        group_mask_o  = '0;
        jalr_stall_o  = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (!redirect_valid_i) begin
                    fetch_valid_o = 1'b1;
                    group_mask_o  = (cf_is_branch || cf_is_jalr) ? slot_mask(cf_slot) : '1;
                    if (fetch_ready_i) begin
                        if (cf_is_branch) begin
                            pc_d = branch_target_i & AlignMask;
                        end else if (cf_is_jalr) begin
                            if (jalr_prediction_valid_i) begin
                                pc_d = jalr_prediction_target_i & AlignMask;
                            end else begin
`ifdef JALR_STALL_ON_MISS_EN
                                state_d = WAIT_JALR;
`else
                                pc_d = pc_q + ADDR_WIDTH'({({1'b0, jalr_slot} + 4'd1), 2'b00});
`endif
                            end
                        end else begin
                            pc_d = pc_q + GroupStep;
                        end
                    end
                end
            end
            WAIT_JALR: begin
                jalr_stall_o = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (redirect_valid_i) begin
            pc_d    = redirect_pc_i & AlignMask;
            state_d = FETCH;
        end

        if (reset) begin
            fetch_valid_o = 1'b0;
            group_mask_o  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= FETCH;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

`ifdef JALR_STALL_ON_MISS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == WAIT_JALR) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count_o = stall_cnt_q;
`else
    assign stall_count_o = '0;
`endif

endmodule

// File: tb/tb_fetch_next_pc_gen.sv
// Scoreboard bench for fetch_next_pc_gen: the driver queues each expected
// consumed group, the monitor pops and compares on every valid&&ready cycle.
module tb_fetch_next_pc_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] current_pc_0, current_pc_1, current_pc_2, current_pc_3, current_pc_4;
    logic        is_jalr_i_0, is_jalr_i_1, is_jalr_i_2, is_jalr_i_3, is_jalr_i_4;
    logic        jalr_prediction_valid_i;
    logic [31:0] jalr_prediction_target_i;
    logic        branch_taken_i;
    logic [2:0]  branch_slot_i;
    logic [31:0] branch_target_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        fetch_ready_i;
    logic        fetch_valid_o;
    logic [4:0]  group_mask_o;
    logic        jalr_stall_o;
    logic [15:0] stall_count_o;

    typedef struct packed {
        logic [31:0] pc0;
        logic [31:0] pc4;
        logic [4:0]  mask;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fetch_next_pc_gen dut (
        .clk                      (clk),
        .reset                    (reset),
        .current_pc_0             (current_pc_0),
        .current_pc_1             (current_pc_1),
        .current_pc_2             (current_pc_2),
        .current_pc_3             (current_pc_3),
        .current_pc_4             (current_pc_4),
        .is_jalr_i_0              (is_jalr_i_0),
        .is_jalr_i_1              (is_jalr_i_1),
        .is_jalr_i_2              (is_jalr_i_2),
        .is_jalr_i_3              (is_jalr_i_3),
        .is_jalr_i_4              (is_jalr_i_4),
        .jalr_prediction_valid_i  (jalr_prediction_valid_i),
        .jalr_prediction_target_i (jalr_prediction_target_i),
        .branch_taken_i           (branch_taken_i),
        .branch_slot_i            (branch_slot_i),
        .branch_target_i          (branch_target_i),
        .redirect_valid_i         (redirect_valid_i),
        .redirect_pc_i            (redirect_pc_i),
        .fetch_ready_i            (fetch_ready_i),
        .fetch_valid_o            (fetch_valid_o),
        .group_mask_o             (group_mask_o),
        .jalr_stall_o             (jalr_stall_o),
        .stall_count_o            (stall_count_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        is_jalr_i_0 = 0; is_jalr_i_1 = 0; is_jalr_i_2 = 0; is_jalr_i_3 = 0; is_jalr_i_4 = 0;
        jalr_prediction_valid_i  = 0;
        jalr_prediction_target_i = '0;
        branch_taken_i           = 0;
        branch_slot_i            = '0;
        branch_target_i          = '0;
        redirect_valid_i         = 0;
        redirect_pc_i            = '0;
        fetch_ready_i            = 1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic expect_grp(input logic [31:0] pc0, input logic [31:0] pc4,
                              input logic [4:0] mask);
        exp_q.push_back('{pc0: pc0, pc4: pc4, mask: mask});
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid_i = 1;
        redirect_pc_i    = pc;
    endtask

    // Monitor: every consumed group must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && fetch_valid_o && fetch_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_group: got pc 0x%08h expected no group", current_pc_0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("grp_pc0", current_pc_0, e.pc0);
                check("grp_pc4", current_pc_4, e.pc4);
                check("grp_mask", {27'd0, group_mask_o}, {27'd0, e.mask});
            end
        end
    end

    initial begin
        idle();
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, fetch_valid_o}, 32'd0);
        check("rst_mask", {27'd0, group_mask_o}, 32'd0);
        check("rst_stall", {31'd0, jalr_stall_o}, 32'd0);
        check("rst_count", {16'd0, stall_count_o}, 32'd0);
        check("rst_pc0", current_pc_0, 32'h0);
        check("rst_pc4", current_pc_4, 32'h10);

        // Sequential groups from RESET_PC
        @(posedge clk); #1; idle(); reset = 0;
        expect_grp(32'h0, 32'h10, 5'b11111);
        next_cycle(); expect_grp(32'h14, 32'h24, 5'b11111);
        next_cycle(); expect_grp(32'h28, 32'h38, 5'b11111);
        next_cycle(); redirect(32'h100);

        // Predicted JALR in slot 2
        next_cycle();
        is_jalr_i_2 = 1; jalr_prediction_valid_i = 1; jalr_prediction_target_i = 32'h400;
        expect_grp(32'h100, 32'h110, 5'b00111);
        next_cycle(); expect_grp(32'h400, 32'h410, 5'b11111);
        next_cycle(); redirect(32'h101);

        // Branch slot 1 beats JALR slot 3; target low bits cleared
        next_cycle();
        is_jalr_i_3 = 1; jalr_prediction_valid_i = 1; jalr_prediction_target_i = 32'h999;
        branch_taken_i = 1; branch_slot_i = 3'd1; branch_target_i = 32'h203;
        expect_grp(32'h100, 32'h110, 5'b00011);
        next_cycle(); expect_grp(32'h200, 32'h210, 5'b11111);
        next_cycle(); redirect(32'h100);

        // Unpredicted JALR in slot 0
        next_cycle(); is_jalr_i_0 = 1; expect_grp(32'h100, 32'h110, 5'b00001);
`ifdef JALR_STALL_ON_MISS_EN
        next_cycle();
        @(negedge clk);
        check("wait_stall", {31'd0, jalr_stall_o}, 32'd1);
        check("wait_valid", {31'd0, fetch_valid_o}, 32'd0);
        check("wait_mask", {27'd0, group_mask_o}, 32'd0);
        check("wait_count0", {16'd0, stall_count_o}, 32'd0);
        next_cycle(); next_cycle(); next_cycle();
        redirect(32'h803);
        @(negedge clk);
        check("wait_count3", {16'd0, stall_count_o}, 32'd3);
        next_cycle(); expect_grp(32'h800, 32'h810, 5'b11111);
        @(negedge clk);
        check("redir_count", {16'd0, stall_count_o}, 32'd4);
        check("redir_stall", {31'd0, jalr_stall_o}, 32'd0);
        next_cycle(); expect_grp(32'h814, 32'h824, 5'b11111);
        @(negedge clk);
        check("fetch_count_hold", {16'd0, stall_count_o}, 32'd4);

        // Reset while waiting on a JALR
        next_cycle(); redirect(32'h100);
        next_cycle(); is_jalr_i_0 = 1; expect_grp(32'h100, 32'h110, 5'b00001);
        next_cycle();
        next_cycle(); reset = 1;
        #1;
        check("midrst_count", {16'd0, stall_count_o}, 32'd0);
        check("midrst_stall", {31'd0, jalr_stall_o}, 32'd0);
        check("midrst_pc0", current_pc_0, 32'h0);
        next_cycle(); reset = 0; expect_grp(32'h0, 32'h10, 5'b11111);
`else
        next_cycle(); expect_grp(32'h104, 32'h114, 5'b11111);
        @(negedge clk);
        check("nostall_stall", {31'd0, jalr_stall_o}, 32'd0);
        check("nostall_count", {16'd0, stall_count_o}, 32'd0);
`endif

        // Back-pressure holds the group
        next_cycle(); redirect(32'h40);
        for (int i = 0; i < 4; i++) begin
            next_cycle(); fetch_ready_i = 0;
            @(negedge clk);
            check("hold_valid", {31'd0, fetch_valid_o}, 32'd1);
            check("hold_pc0", current_pc_0, 32'h40);
            check("hold_mask", {27'd0, group_mask_o}, 32'h1f);
        end
        next_cycle(); fetch_ready_i = 0; redirect(32'h1000);
        @(negedge clk);
        check("hold_redir_valid", {31'd0, fetch_valid_o}, 32'd0);
        next_cycle(); expect_grp(32'h1000, 32'h1010, 5'b11111);

        // Wraparound at the top of the address space
        next_cycle(); redirect(32'hFFFF_FFF0);
        next_cycle(); expect_grp(32'hFFFF_FFF0, 32'h0, 5'b11111);
        next_cycle();
        branch_taken_i = 1; branch_slot_i = 3'd4; branch_target_i = 32'h300;
        expect_grp(32'h4, 32'h14, 5'b11111);
        next_cycle();
        branch_taken_i = 1; branch_slot_i = 3'd0; branch_target_i = 32'h50;
        expect_grp(32'h300, 32'h310, 5'b00001);
        next_cycle(); expect_grp(32'h50, 32'h60, 5'b11111);
        next_cycle(); fetch_ready_i = 0;
        @(negedge clk);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
